// File: rtl/ic_jpeg_defs.sv
// Shared constants for the JPEG colour-conversion front end: JFIF integer
// coefficients, rounding/level-shift constants and block geometry.
package ic_jpeg_defs;

    localparam int PLANE_WORDS = 16;
    localparam int BLOCK_WORDS = 48;
    localparam int LANES       = 4;

    localparam logic signed [17:0] C_Y_R  = 18'sd77;
    localparam logic signed [17:0] C_Y_G  = 18'sd150;
    localparam logic signed [17:0] C_Y_B  = 18'sd29;
    localparam logic signed [17:0] C_CB_R = 18'sd43;
    localparam logic signed [17:0] C_CB_G = 18'sd85;
    localparam logic signed [17:0] C_CB_B = 18'sd128;
    localparam logic signed [17:0] C_CR_R = 18'sd128;
    localparam logic signed [17:0] C_CR_G = 18'sd107;
    localparam logic signed [17:0] C_CR_B = 18'sd21;
    localparam logic signed [17:0] ROUND  = 18'sd128;
    localparam logic signed [17:0] LEVEL  = 18'sd128;

    // Saturate to 0..255 then subtract 128; in range, that is just an MSB flip.
    function automatic logic [7:0] clamp_shift(input logic signed [17:0] v);
        logic [7:0] res;
        if (v < 18'sd0) begin
            res = 8'h80;
        end else if (v > 18'sd255) begin
            res = 8'h7F;
        end else begin
            res = v[7:0] ^ 8'h80;
        end
        return res;
    endfunction

endpackage

// File: rtl/ic_block_rgb2ycbcr_if.sv
// Valid-only stream bundle between the block gatherer, the colour converter
// and the DCT stage.
interface ic_block_rgb2ycbcr_if;
    logic        YCC_inputready;
    logic [31:0] YCC_readdata;
    logic        YCC_outputready;
    logic [31:0] YCC_Y;
    logic [31:0] YCC_Cb;
    logic [31:0] YCC_Cr;
    logic        YCC_blockdone;

    modport slave (
        input  YCC_inputready, YCC_readdata,
        output YCC_outputready, YCC_Y, YCC_Cb, YCC_Cr, YCC_blockdone
    );

    modport master (
        output YCC_inputready, YCC_readdata,
        input  YCC_outputready, YCC_Y, YCC_Cb, YCC_Cr, YCC_blockdone
    );
endinterface

// File: rtl/ic_ycc_lane.sv
// One-pixel RGB -> level-shifted YCbCr converter: products, rounded sums,
// then clamp and shift, each stage registered under its own enable.
module ic_ycc_lane
    import ic_jpeg_defs::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en_s1,
    input  logic       en_s2,
    input  logic       en_s3,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    output logic [7:0] y_out,
    output logic [7:0] cb_out,
    output logic [7:0] cr_out
);

    logic signed [17:0] r_s, g_s, b_s;
    logic signed [17:0] prod_d [9];
    logic signed [17:0] prod_q [9];
    logic signed [17:0] y2_d, cb2_d, cr2_d;
    logic signed [17:0] y2_q, cb2_q, cr2_q;
    logic [7:0]         y3_d, cb3_d, cr3_d;
    logic [7:0]         y3_q, cb3_q, cr3_q;

    always_comb begin
        r_s = signed'({10'd0, r_in});
        g_s = signed'({10'd0, g_in});
        b_s = signed'({10'd0, b_in});

        // Negative coefficients are folded into the products so stage 2 only adds.
        prod_d[0] = r_s * C_Y_R;
        prod_d[1] = g_s * C_Y_G;
        prod_d[2] = b_s * C_Y_B;
        prod_d[3] = -(r_s * C_CB_R);
        prod_d[4] = -(g_s * C_CB_G);
        prod_d[5] = b_s * C_CB_B;
        prod_d[6] = r_s * C_CR_R;
        prod_d[7] = -(g_s * C_CR_G);
        prod_d[8] = -(b_s * C_CR_B);

        y2_d  = (prod_q[0] + prod_q[1] + prod_q[2] + ROUND) >>> 8;
        cb2_d = ((prod_q[3] + prod_q[4] + prod_q[5] + ROUND) >>> 8) + LEVEL;
        cr2_d = ((prod_q[6] + prod_q[7] + prod_q[8] + ROUND) >>> 8) + LEVEL;

        y3_d  = clamp_shift(y2_q);
        cb3_d = clamp_shift(cb2_q);
        cr3_d = clamp_shift(cr2_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= '0;
            end
            y2_q  <= '0;
            cb2_q <= '0;
            cr2_q <= '0;
            y3_q  <= '0;
            cb3_q <= '0;
            cr3_q <= '0;
        end else begin
            if (en_s1) begin
                for (int i = 0; i < 9; i++) begin
                    prod_q[i] <= prod_d[i];
                end
            end
            if (en_s2) begin
                y2_q  <= y2_d;
                cb2_q <= cb2_d;
                cr2_q <= cr2_d;
            end
            if (en_s3) begin
                y3_q  <= y3_d;
                cb3_q <= cb3_d;
                cr3_q <= cr3_d;
            end
        end
    end

    assign y_out  = y3_q;
    assign cb_out = cb3_q;
    assign cr_out = cr3_q;

endmodule

// File: rtl/ic_block_rgb2ycbcr.sv
// Buffers the R and G planes of an 8x8 tile, then converts 4 pixels per B word
// into level-shifted YCbCr beats for the DCT stage.
module ic_block_rgb2ycbcr
    import ic_jpeg_defs::*;
#(
    parameter int PIPE_STAGES     = 3,
    parameter int WORDS_PER_PLANE = PLANE_WORDS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ic_block_rgb2ycbcr_if.slave   ycc
);

    localparam logic [5:0] G_START   = 6'(WORDS_PER_PLANE);
    localparam logic [5:0] B_START   = 6'(2 * WORDS_PER_PLANE);
    localparam logic [5:0] LAST_WORD = 6'(BLOCK_WORDS - 1);

    logic [5:0]             word_cnt_q, word_cnt_d;
    logic [PIPE_STAGES-1:0] vld_q, vld_d;
    logic [PIPE_STAGES-1:0] last_q, last_d;
    logic [31:0]            r_buf_q [WORDS_PER_PLANE];
    logic [31:0]            g_buf_q [WORDS_PER_PLANE];
    logic [3:0]             idx;
    logic                   accept;
    logic                   in_b;
    logic [31:0]            y_w, cb_w, cr_w;

    always_comb begin
        accept = ycc.YCC_inputready;
        idx    = word_cnt_q[3:0];
        in_b   = accept && (word_cnt_q >= B_START);

        word_cnt_d = word_cnt_q;
        if (accept) begin
            word_cnt_d = (word_cnt_q == LAST_WORD) ? 6'd0 : word_cnt_q + 6'd1;
        end

        vld_d  = {vld_q[PIPE_STAGES-2:0], in_b};
        last_d = {last_q[PIPE_STAGES-2:0], in_b && (word_cnt_q == LAST_WORD)};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt_q <= '0;
            vld_q      <= '0;
            last_q     <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
        end
    end

    // Plane buffers carry no reset; a fresh block always rewrites them before use.
    always_ff @(posedge clk) begin
        if (accept && (word_cnt_q < G_START)) begin
            r_buf_q[idx] <= ycc.YCC_readdata;
        end
        if (accept && (word_cnt_q >= G_START) && (word_cnt_q < B_START)) begin
            g_buf_q[idx] <= ycc.YCC_readdata;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            ic_ycc_lane u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .en_s1   (in_b),
                .en_s2   (vld_q[0]),
                .en_s3   (vld_q[1]),
                .r_in    (r_buf_q[idx][8*gi +: 8]),
                .g_in    (g_buf_q[idx][8*gi +: 8]),
                .b_in    (ycc.YCC_readdata[8*gi +: 8]),
                .y_out   (y_w[8*gi +: 8]),
                .cb_out  (cb_w[8*gi +: 8]),
                .cr_out  (cr_w[8*gi +: 8])
            );
        end
    endgenerate

    assign ycc.YCC_outputready = vld_q[PIPE_STAGES-1];
    assign ycc.YCC_blockdone   = last_q[PIPE_STAGES-1];
    assign ycc.YCC_Y           = y_w;
    assign ycc.YCC_Cb          = cb_w;
    assign ycc.YCC_Cr          = cr_w;

endmodule
